// File: rtl/decoder_strobe_pkg.sv
// Shared types and constants for the decoder_strobe block.
package decoder_strobe_pkg;

    localparam int CODE_W = 2;
    localparam int LINES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_strobe_dec2to4.sv
// Combinational 2-to-4 one-hot decoder with enable.
module dec2to4
    import decoder_strobe_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              en,
    output logic [LINES-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_strobe.sv
// Held one-hot strobe with valid/ready completion and optional per-line
// hit counters (enabled by DECODER_STROBE_HITCNT_EN).
module decoder_strobe
    import decoder_strobe_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [CODE_W-1:0]  in_code,
    input  logic               in_en,
    output logic               in_ready,
    output logic [LINES-1:0]   out_onehot,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [LINES*CNT_W-1:0] hit_cnt
);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [LINES-1:0] onehot_q, onehot_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [LINES-1:0] dec_onehot;
    logic             accept;

    dec2to4 u_dec (
        .code   (in_code),
        .en     (in_en),
        .onehot (dec_onehot)
    );

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE:  in_ready = 1'b1;
                ST_DRAIN: in_ready = out_ready;
                default:  in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_HOLD;
                    cnt_d    = 8'(HOLD - 1);
                    onehot_d = dec_onehot;
                    busy_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_DRAIN;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    // completion and next request share one edge
                    state_d  = ST_HOLD;
                    cnt_d    = 8'(HOLD - 1);
                    onehot_d = dec_onehot;
                    valid_d  = 1'b0;
                end else if (out_ready) begin
                    state_d  = ST_IDLE;
                    onehot_d = '0;
                    valid_d  = 1'b0;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                onehot_d = '0;
                valid_d  = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign out_onehot = onehot_q;
    assign out_valid  = valid_q;
    assign busy       = busy_q;

`ifdef DECODER_STROBE_HITCNT_EN
    logic [LINES-1:0][CNT_W-1:0] hit_q, hit_d;

    always_comb begin
        hit_d = hit_q;
        if (accept && in_en && (hit_q[in_code] != '1)) begin
            hit_d[in_code] = hit_q[in_code] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_cnt = hit_q;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_decoder_strobe.sv
// Directed self-checking bench for decoder_strobe (HOLD=4, CNT_W=2).
module tb_decoder_strobe;

    localparam int HOLD  = 4;
    localparam int CNT_W = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_code;
    logic       in_en;
    logic       in_ready;
    logic [3:0] out_onehot;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [4*CNT_W-1:0] hit_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int exp_hit [4];

    decoder_strobe #(.HOLD(HOLD), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_en      (in_en),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .hit_cnt    (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*CNT_W-1:0] hit_vec();
        logic [4*CNT_W-1:0] v;
        v = '0;
`ifdef DECODER_STROBE_HITCNT_EN
        for (int i = 0; i < 4; i++) v[i*CNT_W +: CNT_W] = CNT_W'(exp_hit[i]);
`endif
        return v;
    endfunction

    function automatic void count_hit(input int line);
        if (exp_hit[line] < (1 << CNT_W) - 1) exp_hit[line]++;
    endfunction

    task automatic chk_out(input string tag, input logic [3:0] oh,
                           input logic v, input logic b);
        chk({tag, "_onehot"}, 32'(out_onehot), 32'(oh));
        chk({tag, "_valid"},  32'(out_valid),  32'(v));
        chk({tag, "_busy"},   32'(busy),       32'(b));
        chk({tag, "_hit"},    32'(hit_cnt),    32'(hit_vec()));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) exp_hit[i] = 0;
        rst = 1'b1; in_valid = 1'b0; in_code = 2'd0; in_en = 1'b0;
        out_ready = 1'b1;
        step(); step();
        chk_out("reset", 4'b0000, 1'b0, 1'b0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0; #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // code 2 enabled, consumer ready
        in_valid = 1'b1; in_code = 2'd2; in_en = 1'b1;
        step(); count_hit(2);
        in_valid = 1'b0; in_code = 2'd0; in_en = 1'b0;
        chk_out("c2_accept", 4'b0100, 1'b0, 1'b1);
        chk("c2_hold_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < HOLD - 1; i++) begin
            step();
            chk_out("c2_hold", 4'b0100, 1'b0, 1'b1);
        end
        step();
        chk_out("c2_drain", 4'b0100, 1'b1, 1'b1);
        chk("c2_drain_ready", 32'(in_ready), 32'd1);
        step();
        chk_out("c2_idle", 4'b0000, 1'b0, 1'b0);

        // disabled decode still handshakes but does not count
        in_valid = 1'b1; in_code = 2'd1; in_en = 1'b0;
        step();
        in_valid = 1'b0; in_en = 1'b1;
        chk_out("en0_accept", 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < HOLD - 1; i++) step();
        step();
        chk_out("en0_drain", 4'b0000, 1'b1, 1'b1);
        step();
        chk_out("en0_idle", 4'b0000, 1'b0, 1'b0);

        // backpressure in DRAIN then back-to-back accept
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 2'd1; in_en = 1'b1;
        step(); count_hit(1);
        in_valid = 1'b0;
        for (int i = 0; i < HOLD; i++) step();
        in_valid = 1'b1; in_code = 2'd3; in_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk_out("bp_drain", 4'b0010, 1'b1, 1'b1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1; #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        step(); count_hit(3);
        in_valid = 1'b0;
        chk_out("b2b_accept", 4'b1000, 1'b0, 1'b1);
        for (int i = 0; i < HOLD; i++) step();
        chk_out("b2b_drain", 4'b1000, 1'b1, 1'b1);
        step();
        chk_out("b2b_idle", 4'b0000, 1'b0, 1'b0);

        // saturation of line 0
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_code = 2'd0; in_en = 1'b1;
            step(); count_hit(0);
            in_valid = 1'b0;
            chk_out("sat_accept", 4'b0001, 1'b0, 1'b1);
            for (int i = 0; i < HOLD + 1; i++) step();
        end
`ifdef DECODER_STROBE_HITCNT_EN
        chk("sat_line0", 32'(hit_cnt[0 +: CNT_W]), 32'd3);
`else
        chk("sat_line0", 32'(hit_cnt[0 +: CNT_W]), 32'd0);
`endif

        // reset during HOLD discards everything
        in_valid = 1'b1; in_code = 2'd3; in_en = 1'b1;
        step(); count_hit(3);
        in_valid = 1'b0;
        step();
        chk_out("pre_rst_hold", 4'b1000, 1'b0, 1'b1);
        rst = 1'b1; in_valid = 1'b1; #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        for (int i = 0; i < 4; i++) exp_hit[i] = 0;
        chk_out("rst_mid", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0; in_valid = 1'b0; #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);
        step();
        chk_out("rst_idle", 4'b0000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
